pipe_run_monitor: RTL and testbench
===================================

# pipe_run_monitor

Parametrised run controller for pipelined-CPU simulation benches. It watches the write-back stage retire stream and counts cycles and retired instructions. It detects program end, either by an explicit end PC or by a self-loop halt (the same PC retiring repeatedly). It lets the pipeline drain, then raises a dump-request handshake so the bench prints the register file and data memory. It sits beside `CPU`, tapping `WB_PC` and a retire-valid strobe, and replaces fixed-cycle-count stop logic with a deterministic end-of-program condition plus a timeout.

## Interface
- `PC_W`, 32, PC width.
- `CNT_W`, 32, width of the cycle and retire counters.
- `END_PC`, 0, PC whose retirement ends the run; 0 disables this check.
- `HALT_REPEAT`, 3, number of consecutive retirements of the same PC that count as a halt; minimum 2.
- `DRAIN_CYCLES`, 4, cycles to wait after halt detection before dumping; minimum 1.
- `MAX_CYCLES`, 1000, cycle count in RUN that forces a timeout.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset; asynchronous, active-low.
- `start`, in, 1: begin a run; accepted in IDLE or DONE.
- `retire_valid`, in, 1: one instruction retires at WB this cycle.
- `retire_pc`, in, `PC_W`: PC of the retiring instruction.
- `dump_ack`, in, 1: bench has finished dumping.
- `running`, out, 1: high in RUN or DRAIN.
- `dump_req`, out, 1: dump request.
- `done`, out, 1: run finished and dump acknowledged.
- `timed_out`, out, 1: sticky; the run ended by timeout.
- `cycle_count`, out, `CNT_W`: cycles spent in RUN and DRAIN.
- `retire_count`, out, `CNT_W`: instructions retired in RUN and DRAIN.
- `last_pc`, out, `PC_W`: PC of the most recent retirement.

## Operation
- States: IDLE, RUN, DRAIN, DUMP, DONE.
- Reset values: state IDLE, all outputs 0, internal repeat and drain counters 0.

IDLE:
- Counters are held.
- `start`=1 moves to RUN. On that edge, `cycle_count`, `retire_count`, `last_pc`, the repeat counter and `timed_out` are all cleared.

RUN:
- `cycle_count` increments every cycle.
- On each cycle with `retire_valid`=1:
  - `retire_count` increments.
  - `last_pc` is updated to `retire_pc`.
  - The repeat counter becomes `rep+1` if `retire_pc==last_pc`, otherwise 1.
- Halt condition, evaluated on a retire cycle: `retire_pc==END_PC` (when `END_PC`≠0), or the next repeat value equals `HALT_REPEAT`.
- On halt the state moves to DRAIN and the drain counter loads `DRAIN_CYCLES-1`.
- Timeout: if `cycle_count==MAX_CYCLES-1` and there is no halt this cycle, set `timed_out` and go directly to DUMP.
- A halt and a timeout in the same cycle resolve as a halt; `timed_out` stays 0.

DRAIN:
- `cycle_count` and `retire_count` keep counting. The repeat logic is frozen.
- When the drain counter reaches 0, move to DUMP; otherwise decrement it.

DUMP:
- `dump_req`=1 and the counters are frozen.
- `dump_ack`=1 moves to DONE.

DONE:
- `done`=1 and the counters are frozen.
- `start` restarts the run exactly as from IDLE.

General rules:
- `dump_ack` is ignored outside DUMP. `start` is ignored in RUN, DRAIN and DUMP.
- Counters saturate at all-ones and never wrap.
- `retire_valid` is ignored outside RUN and DRAIN.
- Asserting `rst` in any state returns to IDLE immediately and clears all outputs.

## Timing
- All outputs are registered; no combinational path runs from input to output.
- `running` rises on the edge after `start` is sampled.
- Halt latency: a halting retirement sampled at edge N gives `running` high through edge N+`DRAIN_CYCLES`. `dump_req` rises at edge N+`DRAIN_CYCLES`.
- `dump_ack` sampled at edge M drops `dump_req` and raises `done` at edge M. A 1-cycle ack pulse is sufficient.
- Timeout: `dump_req` rises on the edge where the RUN cycle index `MAX_CYCLES-1` is sampled. `cycle_count` then reads `MAX_CYCLES`.

## Structure
- A shared package `sim_ctrl_pkg` holds the state encoding (3-bit, named constants) and the default `TEXT_BASE_ADDRESS` (0x3000) and `DATA_BASE_ADDRESS` (0x0000) constants used by benches.
- One natural sub-module is `sat_counter`, a parametrised-width saturating counter with clear and enable. It is instantiated twice, for the cycle and retire counters.

## Test plan
- End PC: `END_PC`=0x3048; retire 0x3000..0x3048 one per cycle (19 instructions) → DRAIN for 4 cycles, then `dump_req`; `retire_count`=19; `last_pc`=0x3048.
- Self-loop halt: `END_PC`=0; retire 0x3040 three consecutive times after 10 distinct PCs → halt on the third retirement; `retire_count`=13; `timed_out`=0.
- Broken repeat: pattern 0x3040, 0x3040, 0x3044, 0x3040 → no halt; the repeat counter restarts at 1.
- Timeout: `MAX_CYCLES`=50, no halt → `dump_req` rises with `cycle_count`=50 and `timed_out`=1; ack → `done`=1.
- Handshake: hold `dump_ack` low for 7 cycles → `dump_req` stays high and counters are frozen; a 1-cycle ack → `done` on the next edge. An ack pulse during RUN has no effect.
- Reset and restart: assert `rst` mid-DRAIN → IDLE immediately, all outputs 0. `start` in DONE → counters clear and RUN begins.

Source files
------------

// File: rtl/sim_ctrl_pkg.sv
// sim_ctrl_pkg
// Shared definitions for the simulation run controller and the benches that
// drive it: the run-state encoding, the default text/data base addresses used
// when loading programs, and a small state-classification helper.
package sim_ctrl_pkg;

  // Run controller states, 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DUMP  = 3'd3,
    ST_DONE  = 3'd4
  } run_state_t;

  // Default program layout used by the CPU benches.
  localparam logic [31:0] TEXT_BASE_ADDRESS = 32'h0000_3000;
  localparam logic [31:0] DATA_BASE_ADDRESS = 32'h0000_0000;

  // The pipeline is considered "running" while instructions may still retire.
  function automatic logic is_active(input run_state_t s);
    return (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Parametrised-width up counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-low reset, clears the count
//   clr   - synchronous clear, takes priority over en
//   en    - count enable
//   count - current count value
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  // Clear wins over enable; once all-ones is reached the count holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_run_monitor.sv
// pipe_run_monitor
// Run controller for pipelined-CPU simulation benches. Watches the WB retire
// stream, counts cycles and retirements, detects program end (explicit end PC
// or a self-loop halt), lets the pipeline drain, then requests a dump of the
// architectural state through a req/ack handshake. A cycle budget forces a
// timeout if the program never ends.
// Ports:
//   clk, rst          - clock (rising edge), asynchronous active-low reset
//   start             - begin a run (accepted in IDLE or DONE)
//   retire_valid      - one instruction retires at WB this cycle
//   retire_pc         - PC of the retiring instruction
//   dump_ack          - bench has finished dumping
//   running           - high in RUN or DRAIN
//   dump_req          - dump request, high in DUMP
//   done              - run finished and dump acknowledged
//   timed_out         - sticky, the run ended by timeout
//   cycle_count       - cycles spent in RUN and DRAIN
//   retire_count      - instructions retired in RUN and DRAIN
//   last_pc           - PC of the most recent retirement
module pipe_run_monitor
  import sim_ctrl_pkg::*;
#(
  parameter int              PC_W         = 32,
  parameter int              CNT_W        = 32,
  parameter logic [PC_W-1:0] END_PC       = '0,
  parameter int              HALT_REPEAT  = 3,
  parameter int              DRAIN_CYCLES = 4,
  parameter int              MAX_CYCLES   = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             retire_valid,
  input  logic [PC_W-1:0]  retire_pc,
  input  logic             dump_ack,
  output logic             running,
  output logic             dump_req,
  output logic             done,
  output logic             timed_out,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retire_count,
  output logic [PC_W-1:0]  last_pc
);

  // The repeat counter never needs to exceed HALT_REPEAT: reaching it halts.
  localparam int REP_W = $clog2(HALT_REPEAT + 1);
  localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);

  localparam logic [REP_W-1:0] HALT_REP   = REP_W'(HALT_REPEAT);
  localparam logic [DRN_W-1:0] DRAIN_LOAD = DRN_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_AT = CNT_W'(MAX_CYCLES - 1);
  localparam logic             END_EN     = (END_PC != '0);

  run_state_t       state;
  run_state_t       next_state;
  logic [REP_W-1:0] rep;
  logic [REP_W-1:0] next_rep;
  logic [DRN_W-1:0] drain_cnt;
  logic             start_go;
  logic             in_run;
  logic             active;
  logic             halt;
  logic             timeout;

  // Halt and timeout decisions. A halt on the same cycle as the timeout
  // threshold takes precedence, so the run is reported as a clean finish.
  always_comb begin
    start_go = start && ((state == ST_IDLE) || (state == ST_DONE));
    in_run   = (state == ST_RUN);
    active   = is_active(state);
    next_rep = (retire_pc == last_pc) ? (rep + REP_W'(1)) : REP_W'(1);
    halt     = in_run && retire_valid &&
               ((END_EN && (retire_pc == END_PC)) || (next_rep == HALT_REP));
    timeout  = in_run && !halt && (cycle_count == TIMEOUT_AT);
  end

  // Next-state selection.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (start) next_state = ST_RUN;
      ST_RUN: begin
        if (halt)         next_state = ST_DRAIN;
        else if (timeout) next_state = ST_DUMP;
      end
      ST_DRAIN: if (drain_cnt == '0) next_state = ST_DUMP;
      ST_DUMP:  if (dump_ack) next_state = ST_DONE;
      ST_DONE:  if (start) next_state = ST_RUN;
      default:  next_state = ST_IDLE;
    endcase
  end

  // State register plus registered status outputs. The status flags are
  // decoded from next_state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      running   <= 1'b0;
      dump_req  <= 1'b0;
      done      <= 1'b0;
      timed_out <= 1'b0;
      last_pc   <= '0;
      rep       <= '0;
      drain_cnt <= '0;
    end else begin
      state    <= next_state;
      running  <= is_active(next_state);
      dump_req <= (next_state == ST_DUMP);
      done     <= (next_state == ST_DONE);

      if (start_go) begin
        timed_out <= 1'b0;
        last_pc   <= '0;
        rep       <= '0;
      end else begin
        // Repeat tracking only runs in RUN; in DRAIN it is frozen.
        if (in_run && retire_valid) begin
          rep <= next_rep;
        end
        if (active && retire_valid) begin
          last_pc <= retire_pc;
        end
        if (timeout) begin
          timed_out <= 1'b1;
        end
      end

      if (halt) begin
        drain_cnt <= DRAIN_LOAD;
      end else if ((state == ST_DRAIN) && (drain_cnt != '0)) begin
        drain_cnt <= drain_cnt - DRN_W'(1);
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_go),
    .en    (active),
    .count (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_retire_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_go),
    .en    (active && retire_valid),
    .count (retire_count)
  );

endmodule

// File: tb/tb_pipe_run_monitor.sv
// tb_pipe_run_monitor
// Directed bench for pipe_run_monitor. Each scenario pushes the expected dump
// snapshot (cycles, retirements, last PC, timeout flag) into a scoreboard
// queue; a monitor pops and compares whenever dump_req rises. Handshake,
// reset and timing points are checked inline by the stimulus.
module tb_pipe_run_monitor;
  import sim_ctrl_pkg::*;

  localparam logic [31:0] END_PC_TB = 32'h0000_3048;

  typedef struct {
    logic [31:0] cycles;
    logic [31:0] retires;
    logic [31:0] pc;
    logic        tmo;
  } dump_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        retire_valid = 1'b0;
  logic [31:0] retire_pc = '0;
  logic        dump_ack = 1'b0;
  logic        running;
  logic        dump_req;
  logic        done;
  logic        timed_out;
  logic [31:0] cycle_count;
  logic [31:0] retire_count;
  logic [31:0] last_pc;

  dump_exp_t exp_q[$];
  int        n_checks = 0;
  int        n_pass   = 0;
  logic      dump_req_q;

  pipe_run_monitor #(
    .PC_W         (32),
    .CNT_W        (32),
    .END_PC       (END_PC_TB),
    .HALT_REPEAT  (3),
    .DRAIN_CYCLES (4),
    .MAX_CYCLES   (50)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .retire_valid (retire_valid),
    .retire_pc    (retire_pc),
    .dump_ack     (dump_ack),
    .running      (running),
    .dump_req     (dump_req),
    .done         (done),
    .timed_out    (timed_out),
    .cycle_count  (cycle_count),
    .retire_count (retire_count),
    .last_pc      (last_pc)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic apply_retire(input logic [31:0] pc);
    retire_valid = 1'b1;
    retire_pc    = pc;
    step(1);
    retire_valid = 1'b0;
  endtask

  task automatic wait_dump(input int bound);
    int k = 0;
    while (!dump_req && k < bound) begin
      step(1);
      k++;
    end
    check_output("dump_req_within_bound", 32'(dump_req), 32'd1);
  endtask

  task automatic apply_ack();
    dump_ack = 1'b1;
    step(1);
    dump_ack = 1'b0;
    check_output("ack_done", 32'(done), 32'd1);
    check_output("ack_dump_req_low", 32'(dump_req), 32'd0);
  endtask

  // Scoreboard monitor: every rising dump_req must match the oldest snapshot.
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      dump_req_q <= 1'b0;
    end else begin
      dump_req_q <= dump_req;
      if (dump_req && !dump_req_q) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("[TB] FAIL unexpected_dump: got dump_req with no snapshot pending, expected none");
        end else begin
          dump_exp_t e;
          n_pass++;
          e = exp_q.pop_front();
          check_output("sb_cycle_count", cycle_count, e.cycles);
          check_output("sb_retire_count", retire_count, e.retires);
          check_output("sb_last_pc", last_pc, e.pc);
          check_output("sb_timed_out", 32'(timed_out), 32'(e.tmo));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 100us");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    step(3);
    check_output("rst_running", 32'(running), 32'd0);
    check_output("rst_dump_req", 32'(dump_req), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_cycle_count", cycle_count, 32'd0);
    rst = 1'b1;
    step(2);

    // End-PC halt: 19 retirements 0x3000..0x3048, halt at E19, drain 4
    exp_q.push_back('{32'd23, 32'd19, 32'h3048, 1'b0});
    apply_start();
    check_output("t1_running_after_start", 32'(running), 32'd1);
    check_output("t1_cycle_after_start", cycle_count, 32'd0);
    for (int i = 0; i < 19; i++) apply_retire(32'h3000 + 32'(4 * i));
    check_output("t1_drain_running", 32'(running), 32'd1);
    step(3);
    check_output("t1_drain_no_req_yet", 32'(dump_req), 32'd0);
    check_output("t1_drain_still_running", 32'(running), 32'd1);
    step(1);
    check_output("t1_dump_req_rise", 32'(dump_req), 32'd1);
    check_output("t1_running_drop", 32'(running), 32'd0);

    // Handshake: ack held low for 7 cycles, retirements ignored in DUMP
    retire_valid = 1'b1;
    retire_pc    = 32'h3999;
    step(7);
    retire_valid = 1'b0;
    check_output("hs_dump_req_held", 32'(dump_req), 32'd1);
    check_output("hs_cycle_frozen", cycle_count, 32'd23);
    check_output("hs_retire_frozen", retire_count, 32'd19);
    check_output("hs_last_pc_frozen", last_pc, 32'h3048);
    apply_ack();

    // Self-loop halt from DONE, with an ack pulse during RUN
    exp_q.push_back('{32'd17, 32'd13, 32'h3040, 1'b0});
    apply_start();
    check_output("t2_done_cleared", 32'(done), 32'd0);
    check_output("t2_retire_cleared", retire_count, 32'd0);
    check_output("t2_last_pc_cleared", last_pc, 32'd0);
    for (int i = 0; i < 10; i++) begin
      dump_ack = (i >= 3 && i <= 5);
      apply_retire(32'h3000 + 32'(4 * i));
    end
    dump_ack = 1'b0;
    check_output("t2_ack_in_run_ignored", 32'(running), 32'd1);
    for (int i = 0; i < 3; i++) apply_retire(32'h3040);
    check_output("t2_halt_drain", 32'(running), 32'd1);
    wait_dump(10);
    apply_ack();

    // Reset mid-DRAIN, then counters held in IDLE
    apply_start();
    for (int i = 0; i < 3; i++) apply_retire(32'h3100);
    step(1);
    check_output("t3_in_drain", 32'(running), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_output("t3_rst_running", 32'(running), 32'd0);
    check_output("t3_rst_cycle", cycle_count, 32'd0);
    check_output("t3_rst_retire", retire_count, 32'd0);
    check_output("t3_rst_last_pc", last_pc, 32'd0);
    step(1);
    rst = 1'b1;
    retire_valid = 1'b1;
    retire_pc    = 32'h3200;
    step(3);
    retire_valid = 1'b0;
    check_output("t3_idle_retire_held", retire_count, 32'd0);
    check_output("t3_idle_last_pc_held", last_pc, 32'd0);

    // Broken repeat then timeout at MAX_CYCLES
    exp_q.push_back('{32'd50, 32'd5, 32'h3040, 1'b1});
    apply_start();
    apply_retire(32'h3040);
    apply_retire(32'h3040);
    apply_retire(32'h3044);
    apply_retire(32'h3040);
    apply_retire(32'h3040);
    check_output("t4_no_halt", 32'(running), 32'd1);
    check_output("t4_not_timed_out_yet", 32'(timed_out), 32'd0);
    wait_dump(100);
    apply_ack();
    check_output("t4_timed_out_sticky", 32'(timed_out), 32'd1);

    // Halt on the timeout cycle resolves as a halt
    exp_q.push_back('{32'd54, 32'd1, 32'h3048, 1'b0});
    apply_start();
    step(49);
    apply_retire(END_PC_TB);
    check_output("t5_halt_wins", 32'(running), 32'd1);
    check_output("t5_no_timeout", 32'(timed_out), 32'd0);
    wait_dump(10);
    apply_ack();

    step(2);
    check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
